mem_access_unit: RTL and testbench

Unified instruction/data memory stage for the multicycle MIPS datapath, directly downstream of the main controller. Takes the controller's `memread`/`memwrite`/`IorD`/`IR_write` strobes, selects the address from PC or ALUOut, and runs a fixed-latency word access against an internal memory array. Holds the Instruction Register and Memory Data Register, and returns a one-cycle `mem_ready` so the controller can stall its current state until the access completes. Drives `opcode`/`funct` back to the controller.

---
 rtl/mem_access_if.sv | 28 ++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Controller-facing bundle of the unified memory stage: request strobes,
// addresses and store data in, handshake and IR/MDR contents out.
interface mem_access_if;
    logic        memread;
    logic        memwrite;
    logic        IorD;
    logic        IR_write;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] wdata;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    modport master (
        output memread, memwrite, IorD, IR_write, pc, aluout, wdata,
        input  mem_ready, mem_busy, mem_err, ir, mdr, opcode, funct
    );

    modport slave (
        input  memread, memwrite, IorD, IR_write, pc, aluout, wdata,
        output mem_ready, mem_busy, mem_err, ir, mdr, opcode, funct
    );
endinterface

// File: rtl/mem_access_unit.sv
// Unified instruction/data memory stage for the multicycle MIPS datapath:
// fixed-latency word access, Instruction Register and Memory Data Register.
module mem_access_unit #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);
    localparam int IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]      state_q;
    logic [3:0]      cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            rd_q;
    logic            wr_q;
    logic            ircap_q;
    logic            ready_q;
    logic            busy_q;
    logic            err_q;
    logic [31:0]     ir_q;
    logic [31:0]     mdr_q;
    logic [31:0]     mem [0:MEM_WORDS-1];

    logic            reject;
    logic            fire;
    logic            wr_en;
    logic [IdxW-1:0] mem_idx;

    // Rejection is judged on the latched request so late input changes cannot affect it.
    assign reject  = (rd_q & wr_q) | (addr_q[1:0] != 2'b00);
    assign fire    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign wr_en   = fire & wr_q & ~reject & reset;
    assign mem_idx = IdxW'(addr_q[31:2] % 30'(MEM_WORDS));

    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;
    assign bus.ir        = ir_q;
    assign bus.mdr       = mdr_q;
    assign bus.opcode    = ir_q[31:26];
    assign bus.funct     = ir_q[5:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ircap_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.memread | bus.memwrite) begin
                        addr_q  <= bus.IorD ? bus.aluout : bus.pc;
                        wdata_q <= bus.wdata;
                        rd_q    <= bus.memread;
                        wr_q    <= bus.memwrite;
                        ircap_q <= bus.memread & bus.IR_write & ~bus.memwrite;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (rd_q && !reject) begin
                            mdr_q <= mem[mem_idx];
                            if (ircap_q)
                                ir_q <= mem[mem_idx];
                        end
                        ready_q <= 1'b1;
                        err_q   <= reject;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The array itself is never reset; its contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[mem_idx] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, store/load, fetch, rejects,
// address wrap, latched inputs and reset during a write.
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_access_if bus ();

    mem_access_unit #(
        .MEM_WORDS   (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from an IDLE cycle and waits (bounded) for mem_ready.
    task automatic do_access(input logic rd, input logic wr, input logic iord, input logic irw,
                             input logic [31:0] addr, input logic [31:0] data, input bit toggle,
                             output int lat, output logic err_o,
                             output logic [31:0] mdr_o, output logic [31:0] ir_o);
        @(negedge clk);
        bus.memread  = rd;
        bus.memwrite = wr;
        bus.IorD     = iord;
        bus.IR_write = irw;
        if (iord) begin
            bus.aluout = addr;
            bus.pc     = ~addr;
        end else begin
            bus.pc     = addr;
            bus.aluout = ~addr;
        end
        bus.wdata = data;
        lat   = -1;
        err_o = 1'b0;
        mdr_o = 32'hx;
        ir_o  = 32'hx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (toggle && c == 1) begin
                bus.aluout = bus.aluout + 32'd4;
                bus.pc     = bus.pc + 32'd4;
                bus.wdata  = 32'd0;
            end
            if (bus.mem_ready === 1'b1) begin
                lat   = c;
                err_o = bus.mem_err;
                mdr_o = bus.mdr;
                ir_o  = bus.ir;
                break;
            end
        end
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.IR_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit saw_ready;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0 || bus.mem_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: ready=%b busy=%b err=%b, required 0 0 0",
                     bus.mem_ready, bus.mem_busy, bus.mem_err);
        end
        checks++;
        if (bus.ir !== 32'd0 || bus.mdr !== 32'd0 || bus.opcode !== 6'd0 || bus.funct !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: ir=%h mdr=%h opcode=%h funct=%h, required zeros",
                     bus.ir, bus.mdr, bus.opcode, bus.funct);
        end
        checks++;
        if (dut.state_q !== 2'd0 || dut.cnt_q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: state=%0d cnt=%0d, required 0 0", dut.state_q, dut.cnt_q);
        end
        @(negedge clk);
        reset = 1'b1;
        saw_ready = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready) begin
            errors++;
            $display("[TB] FAIL idle_quiet: ready/busy seen without request, required none");
        end
    endtask

    task automatic test_store_load();
        int lat; logic err; logic [31:0] m, i;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_latency: lat=%0d err=%b, required 4 0", lat, err);
        end
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_latency: lat=%0d err=%b, required 4 0", lat, err);
        end
        checks++;
        if (m !== 32'hDEADBEEF || i !== 32'd0) begin
            errors++;
            $display("[TB] FAIL load_data: mdr=%h ir=%h, required deadbeef 00000000", m, i);
        end
    endtask

    task automatic test_fetch();
        int lat; logic err; logic [31:0] m, i;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h8C220004, 1'b0, lat, err, m, i);
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || i !== 32'h8C220004 || m !== 32'h8C220004) begin
            errors++;
            $display("[TB] FAIL fetch_ir: lat=%0d ir=%h mdr=%h, required 4 8c220004 8c220004", lat, i, m);
        end
        checks++;
        if (bus.opcode !== 6'h23 || bus.funct !== 6'h04) begin
            errors++;
            $display("[TB] FAIL fetch_decode: opcode=%h funct=%h, required 23 04", bus.opcode, bus.funct);
        end
    endtask

    task automatic test_errors();
        int lat; logic err; logic [31:0] m, i;
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || err !== 1'b1 || m !== 32'h8C220004 || i !== 32'h8C220004) begin
            errors++;
            $display("[TB] FAIL misaligned: lat=%0d err=%b mdr=%h ir=%h, required 4 1 8c220004 8c220004",
                     lat, err, m, i);
        end
        do_access(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h55555555, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || err !== 1'b1 || m !== 32'h8C220004) begin
            errors++;
            $display("[TB] FAIL both_strobes: lat=%0d err=%b mdr=%h, required 4 1 8c220004", lat, err, m);
        end
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (m !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_no_write: mdr=%h err=%b, required deadbeef 0", m, err);
        end
    endtask

    task automatic test_wrap_latch();
        int lat; logic err; logic [31:0] m, i;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h12345678, 1'b0, lat, err, m, i);
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (m !== 32'h12345678 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap: mdr=%h err=%b, required 12345678 0", m, err);
        end
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h44444444, 1'b0, lat, err, m, i);
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hA5A5A5A5, 1'b1, lat, err, m, i);
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (m !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL latch_target: mdr=%h, required a5a5a5a5", m);
        end
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (m !== 32'h44444444) begin
            errors++;
            $display("[TB] FAIL latch_neighbor: mdr=%h, required 44444444", m);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic err; logic [31:0] m, i;
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h11111111, 1'b0, lat, err, m, i);
        @(negedge clk);
        bus.memwrite = 1'b1;
        bus.memread  = 1'b0;
        bus.IorD     = 1'b1;
        bus.aluout   = 32'h20;
        bus.wdata    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        checks++;
        if (bus.mem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_in_access: busy=%b, required 1", bus.mem_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== 2'd0 || bus.mem_busy !== 1'b0 || bus.mem_ready !== 1'b0 ||
            bus.mem_err !== 1'b0 || bus.mdr !== 32'd0 || bus.ir !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: state=%0d busy=%b ready=%b err=%b mdr=%h ir=%h, required all 0",
                     dut.state_q, bus.mem_busy, bus.mem_ready, bus.mem_err, bus.mdr, bus.ir);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, err, m, i);
        checks++;
        if (lat != 4 || m !== 32'h11111111) begin
            errors++;
            $display("[TB] FAIL aborted_write: lat=%0d mdr=%h, required 4 11111111", lat, m);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.IR_write = 1'b0;
        bus.pc       = 32'd0;
        bus.aluout   = 32'd0;
        bus.wdata    = 32'd0;
        test_reset();
        test_store_load();
        test_fetch();
        test_errors();
        test_wrap_latch();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
